bluemax_platform_cpu_cpu_debug_mem: RTL and testbench

BLUEMAX_PLATFORM_CPU_CPU_DEBUG_MEM -- requirements
Module: bluemax_platform_cpu_cpu_debug_mem

---
 rtl/bluemax_platform_cpu_cpu_debug_mem.sv | 147 ++++++++++++++
 tb/tb_bluemax_platform_cpu_cpu_debug_mem.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bluemax_platform_cpu_cpu_debug_mem.sv
// Debug-monitor memory shared between the debug command path and a CPU slave port.
// Debug accesses always win; the CPU port is stalled while a debug access is in flight.
module bluemax_platform_cpu_cpu_debug_mem #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [31:0]       cpu_writedata,
    input  logic [3:0]        cpu_byteenable,
    output logic [31:0]       cpu_readdata,
    output logic              cpu_waitrequest
);

    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_ADDR = 2'd1,
        RD_CAP  = 2'd2,
        WR      = 2'd3
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   mon_a;
    logic [DATA_W-1:0]   rd_q;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                any_take;
    logic                is_idle;
    logic                drop;
    logic                err_clear;
    logic                dbg_rd;
    logic                dbg_wr;
    logic                cpu_rd_acc;
    logic                cpu_wr_acc;
    logic [ADDR_W-1:0]   ram_addr;
    logic                ram_we;
    logic [BE_W-1:0]     ram_be;
    logic [DATA_W-1:0]   ram_wdata;
    logic [DATA_W-1:0]   ram_rdata;
    logic                unused_jdo;

    // Command payload bits outside the address/data/control fields carry nothing here.
    assign unused_jdo = ^{jdo[37:36], jdo[1:0]};

    // Port arbitration, dropped-command detection and RAM port steering.
    assign any_take        = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign is_idle         = (state == IDLE);
    assign cpu_waitrequest = !is_idle | any_take;
    assign drop            = is_idle ? (take_action_ocimem_a ? (take_action_ocimem_b | take_no_action_ocimem_a)
                                                             : (take_action_ocimem_b & take_no_action_ocimem_a))
                                     : any_take;
    assign err_clear       = is_idle & take_action_ocimem_a & jdo[34];
    assign dbg_rd          = (state == RD_ADDR);
    assign dbg_wr          = (state == WR);
    assign cpu_wr_acc      = cpu_write & !cpu_waitrequest;
    assign cpu_rd_acc      = cpu_read & !cpu_write & !cpu_waitrequest;
    assign ram_addr        = (dbg_rd | dbg_wr) ? mon_a : cpu_address;
    assign ram_we          = reset_n & (dbg_wr | cpu_wr_acc);
    assign ram_be          = dbg_wr ? {BE_W{1'b1}} : cpu_byteenable;
    assign ram_wdata       = dbg_wr ? MonDReg : cpu_writedata;
    assign ram_rdata       = mem[ram_addr];

    // Single-port RAM write with byte lanes; contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < int'(BE_W); b++) begin
                if (ram_be[b]) begin
                    mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
                end
            end
        end
    end

    // Debug command FSM, monitor status registers and CPU read data register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            mon_a         <= '0;
            MonDReg       <= '0;
            rd_q          <= '0;
            monitor_ready <= 1'b1;
            monitor_error <= 1'b0;
            cpu_readdata  <= '0;
        end else begin
            if (cpu_rd_acc) begin
                cpu_readdata <= ram_rdata;
            end

            if (drop) begin
                monitor_error <= 1'b1;
            end else if (err_clear) begin
                monitor_error <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (take_action_ocimem_a) begin
                        mon_a <= jdo[ADDR_W+1:2];
                        if (jdo[35]) begin
                            state         <= RD_ADDR;
                            monitor_ready <= 1'b0;
                        end
                    end else if (take_action_ocimem_b) begin
                        MonDReg       <= jdo[34:3];
                        state         <= WR;
                        monitor_ready <= 1'b0;
                    end else if (take_no_action_ocimem_a) begin
                        mon_a         <= mon_a + ADDR_W'(1);
                        state         <= RD_ADDR;
                        monitor_ready <= 1'b0;
                    end
                end
                RD_ADDR: begin
                    rd_q  <= ram_rdata;
                    state <= RD_CAP;
                end
                RD_CAP: begin
                    MonDReg       <= rd_q;
                    state         <= IDLE;
                    monitor_ready <= 1'b1;
                end
                WR: begin
                    mon_a         <= mon_a + ADDR_W'(1);
                    state         <= IDLE;
                    monitor_ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bluemax_platform_cpu_cpu_debug_mem.sv
// Randomized + directed bench for the debug-monitor memory against a transaction-level model.
module tb_bluemax_platform_cpu_cpu_debug_mem;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic        take_no_action_ocimem_a;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;
    logic [7:0]  cpu_address;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_writedata;
    logic [3:0]  cpu_byteenable;
    logic [31:0] cpu_readdata;
    logic        cpu_waitrequest;

    always #5 clk = ~clk;

    bluemax_platform_cpu_cpu_debug_mem #(.ADDR_W(8)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .cpu_address             (cpu_address),
        .cpu_read                (cpu_read),
        .cpu_write               (cpu_write),
        .cpu_writedata           (cpu_writedata),
        .cpu_byteenable          (cpu_byteenable),
        .cpu_readdata            (cpu_readdata),
        .cpu_waitrequest         (cpu_waitrequest)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Transaction-level model: memory image, debug registers, and remaining busy cycles.
    logic [31:0] m_mem [256];
    logic [7:0]  m_a;
    logic [31:0] m_d;
    logic [31:0] m_rdata;
    logic        m_ready;
    logic        m_err;
    int          m_busy;
    bit          m_op_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [37:0] mk_cmd(input bit rd, input bit clr, input logic [7:0] addr);
        return {2'b00, rd, clr, 24'h0, addr, 2'b00};
    endfunction

    function automatic logic [37:0] mk_wr(input logic [31:0] data);
        return {3'b000, data, 3'b000};
    endfunction

    task automatic model_reset();
        m_a     = '0;
        m_d     = '0;
        m_rdata = '0;
        m_ready = 1'b1;
        m_err   = 1'b0;
        m_busy  = 0;
        m_op_rd = 1'b0;
    endtask

    function automatic bit model_wait();
        return (m_busy != 0) || take_action_ocimem_a || take_action_ocimem_b || take_no_action_ocimem_a;
    endfunction

    // Advance the model across one rising edge using the inputs currently driven.
    task automatic model_step();
        bit any_t;
        bit stall;
        any_t = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
        stall = model_wait();
        if (m_busy != 0) begin
            if (any_t) m_err = 1'b1;
            m_busy--;
            if (m_busy == 0) begin
                if (m_op_rd) begin
                    m_d = m_mem[m_a];
                end else begin
                    m_mem[m_a] = m_d;
                    m_a = m_a + 8'd1;
                end
                m_ready = 1'b1;
            end
        end else if (take_action_ocimem_a) begin
            m_a = jdo[9:2];
            if (jdo[34]) m_err = 1'b0;
            if (take_action_ocimem_b | take_no_action_ocimem_a) m_err = 1'b1;
            if (jdo[35]) begin
                m_busy = 2; m_op_rd = 1'b1; m_ready = 1'b0;
            end
        end else if (take_action_ocimem_b) begin
            m_d = jdo[34:3];
            if (take_no_action_ocimem_a) m_err = 1'b1;
            m_busy = 1; m_op_rd = 1'b0; m_ready = 1'b0;
        end else if (take_no_action_ocimem_a) begin
            m_a = m_a + 8'd1;
            m_busy = 2; m_op_rd = 1'b1; m_ready = 1'b0;
        end
        if (!stall) begin
            if (cpu_write) begin
                for (int b = 0; b < 4; b++)
                    if (cpu_byteenable[b]) m_mem[cpu_address][8*b +: 8] = cpu_writedata[8*b +: 8];
            end else if (cpu_read) begin
                m_rdata = m_mem[cpu_address];
            end
        end
    endtask

    task automatic check_outputs();
        check("MonDReg", MonDReg, m_d);
        check("monitor_ready", {31'b0, monitor_ready}, {31'b0, m_ready});
        check("monitor_error", {31'b0, monitor_error}, {31'b0, m_err});
        check("cpu_readdata", cpu_readdata, m_rdata);
    endtask

    // One clock of stimulus: drive, check the combinational stall, clock, check registers.
    task automatic cyc(input bit t_a, input bit t_b, input bit t_n, input logic [37:0] j,
                       input bit rd, input bit wr, input logic [7:0] addr,
                       input logic [31:0] wd, input logic [3:0] be);
        take_action_ocimem_a    = t_a;
        take_action_ocimem_b    = t_b;
        take_no_action_ocimem_a = t_n;
        jdo            = j;
        cpu_read       = rd;
        cpu_write      = wr;
        cpu_address    = addr;
        cpu_writedata  = wd;
        cpu_byteenable = be;
        #1;
        check("cpu_waitrequest", {31'b0, cpu_waitrequest}, {31'b0, model_wait()});
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        cpu_read                = 1'b0;
        cpu_write               = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, '0, 0, 0, '0, '0, '0);
    endtask

    initial begin
        logic [31:0] old_w;
        logic [63:0] r;

        reset_n = 1'b0;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        cpu_address = '0;
        cpu_read = 1'b0;
        cpu_write = 1'b0;
        cpu_writedata = '0;
        cpu_byteenable = '0;
        model_reset();
        #22;
        check("rst_MonDReg", MonDReg, 32'h0);
        check("rst_ready", {31'b0, monitor_ready}, 32'h1);
        check("rst_error", {31'b0, monitor_error}, 32'h0);
        check("rst_readdata", cpu_readdata, 32'h0);
        reset_n = 1'b1;

        // First edge out of reset takes a write command at address 0.
        cyc(0, 1, 0, mk_wr(32'h0BADF00D), 0, 0, '0, '0, '0);
        check("first_cmd_ready", {31'b0, monitor_ready}, 32'h0);
        idle(1);

        // Fill the rest of the memory through the CPU port.
        for (int i = 1; i < 256; i++)
            cyc(0, 0, 0, '0, 0, 1, 8'(i), (i == 32'h20) ? 32'h0 : $urandom, 4'hF);
        cyc(0, 0, 0, '0, 1, 0, 8'h00, '0, '0);
        check("addr0_word", cpu_readdata, 32'h0BADF00D);

        // Debug write then debug read-back at 0x10.
        cyc(1, 0, 0, mk_cmd(0, 0, 8'h10), 0, 0, '0, '0, '0);
        check("addr_only_ready", {31'b0, monitor_ready}, 32'h1);
        cyc(0, 1, 0, mk_wr(32'hDEADBEEF), 0, 0, '0, '0, '0);
        idle(1);
        cyc(1, 0, 0, mk_cmd(1, 0, 8'h10), 0, 0, '0, '0, '0);
        check("rd_ready_low1", {31'b0, monitor_ready}, 32'h0);
        idle(1);
        check("rd_ready_low2", {31'b0, monitor_ready}, 32'h0);
        idle(1);
        check("rd_deadbeef", MonDReg, 32'hDEADBEEF);
        check("rd_ready_back", {31'b0, monitor_ready}, 32'h1);

        // Address wrap after a write at the top word.
        cyc(1, 0, 0, mk_cmd(0, 0, 8'hFF), 0, 0, '0, '0, '0);
        cyc(0, 1, 0, mk_wr(32'h1), 0, 0, '0, '0, '0);
        idle(1);
        cyc(0, 0, 0, '0, 1, 0, 8'hFF, '0, '0);
        check("wrap_word", cpu_readdata, 32'h1);
        cyc(0, 0, 1, '0, 0, 0, '0, '0, '0);
        idle(2);
        check("wrap_next_read", MonDReg, m_mem[1]);

        // Byte-enabled CPU write then read.
        cyc(0, 0, 0, '0, 0, 1, 8'h20, 32'hAABBCCDD, 4'b0101);
        cyc(0, 0, 0, '0, 1, 0, 8'h20, '0, '0);
        check("byte_en_read", cpu_readdata, 32'h00BB00DD);

        // CPU read held across a debug read.
        cyc(1, 0, 0, mk_cmd(1, 0, 8'h30), 1, 0, 8'h40, '0, '0);
        cyc(0, 0, 0, '0, 1, 0, 8'h40, '0, '0);
        cyc(0, 0, 0, '0, 1, 0, 8'h40, '0, '0);
        check("dbg_during_cpu", MonDReg, m_mem[8'h30]);
        cyc(0, 0, 0, '0, 1, 0, 8'h40, '0, '0);
        check("cpu_after_dbg", cpu_readdata, m_mem[8'h40]);

        // Command while busy sets the sticky error; ocimem_a clears it.
        cyc(1, 0, 0, mk_cmd(1, 0, 8'h31), 0, 0, '0, '0, '0);
        cyc(0, 1, 0, mk_wr(32'h12345678), 0, 0, '0, '0, '0);
        check("err_set", {31'b0, monitor_error}, 32'h1);
        idle(3);
        check("err_sticky", {31'b0, monitor_error}, 32'h1);
        cyc(1, 0, 0, mk_cmd(0, 1, 8'h31), 0, 0, '0, '0, '0);
        check("err_clear", {31'b0, monitor_error}, 32'h0);

        // Reset in the middle of a debug write leaves the target word intact.
        cyc(1, 0, 0, mk_cmd(0, 0, 8'h50), 0, 0, '0, '0, '0);
        old_w = m_mem[8'h50];
        cyc(0, 1, 0, mk_wr(~old_w), 0, 0, '0, '0, '0);
        reset_n = 1'b0;
        model_reset();
        #1;
        check("midrst_MonDReg", MonDReg, 32'h0);
        check("midrst_ready", {31'b0, monitor_ready}, 32'h1);
        check("midrst_error", {31'b0, monitor_error}, 32'h0);
        check("midrst_readdata", cpu_readdata, 32'h0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        cyc(0, 0, 0, '0, 1, 0, 8'h50, '0, '0);
        check("midrst_word", cpu_readdata, old_w);

        // Randomized traffic on both ports.
        for (int i = 0; i < 2000; i++) begin
            r = {$urandom, $urandom};
            cyc($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                r[37:0], $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                8'($urandom), $urandom, 4'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
